// File: rtl/hector_pkg.sv
// Shared types for the SLAM mapping blocks: grid coordinates, the signed
// error accumulator used by the line walker, and the walker state encoding.
package hector_pkg;

    localparam int unsigned COORD_WIDTH = 10;

    typedef logic [COORD_WIDTH-1:0]       coord_t;
    typedef logic signed [COORD_WIDTH+1:0] err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } bres_state_t;

endpackage

// File: rtl/bresenham_line.sv
// Bresenham raster line walker. On a start pulse it latches the robot cell
// and the scan endpoint, then emits every cell of the line through a
// valid/ready handshake. Only the endpoint cell is tagged occupied.
module bresenham_line
    import hector_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] x0,
    input  logic [COORD_WIDTH-1:0] y0,
    input  logic [COORD_WIDTH-1:0] x1,
    input  logic [COORD_WIDTH-1:0] y1,
    output logic                   busy,
    output logic                   point_valid,
    input  logic                   point_ready,
    output logic [COORD_WIDTH-1:0] point_x,
    output logic [COORD_WIDTH-1:0] point_y,
    output logic                   point_occupied
);

    localparam logic [COORD_WIDTH-1:0] ONE = {{(COORD_WIDTH-1){1'b0}}, 1'b1};

    bres_state_t state;

    // Latched line endpoints
    logic [COORD_WIDTH-1:0] lx0, ly0, lx1, ly1;
    // Current cell; doubles as the output coordinate
    logic [COORD_WIDTH-1:0] cx, cy;
    // Walk parameters: dx >= 0, dy <= 0, direction bits set for -1 steps
    logic signed [COORD_WIDTH+1:0] dx, dy, err;
    logic                          sx_neg, sy_neg;

    // Setup-phase magnitudes
    logic [COORD_WIDTH-1:0]        abs_x, abs_y;
    logic signed [COORD_WIDTH+1:0] setup_dx, setup_dy;

    // Next-step values
    logic signed [COORD_WIDTH+1:0] e2, next_err;
    logic [COORD_WIDTH-1:0]        next_x, next_y;
    logic                          at_end;

    assign point_x = cx;
    assign point_y = cy;

    // Absolute deltas of the latched endpoints, consumed in SETUP
    always_comb begin
        abs_x    = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
        abs_y    = (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1);
        setup_dx = $signed({2'b00, abs_x});
        setup_dy = -$signed({2'b00, abs_y});
    end

    // One Bresenham step from the current cell; both axes may move at once
    always_comb begin
        e2       = err <<< 1;
        next_err = err;
        next_x   = cx;
        next_y   = cy;
        if (e2 >= dy) begin
            next_err = next_err + dy;
            next_x   = sx_neg ? (cx - ONE) : (cx + ONE);
        end
        if (e2 <= dx) begin
            next_err = next_err + dx;
            next_y   = sy_neg ? (cy - ONE) : (cy + ONE);
        end
        at_end = (cx == lx1) && (cy == ly1);
    end

    // Walker FSM with registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            point_valid    <= 1'b0;
            point_occupied <= 1'b0;
            lx0            <= '0;
            ly0            <= '0;
            lx1            <= '0;
            ly1            <= '0;
            cx             <= '0;
            cy             <= '0;
            dx             <= '0;
            dy             <= '0;
            err            <= '0;
            sx_neg         <= 1'b0;
            sy_neg         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lx0   <= x0;
                        ly0   <= y0;
                        lx1   <= x1;
                        ly1   <= y1;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx             <= setup_dx;
                    dy             <= setup_dy;
                    err            <= setup_dx + setup_dy;
                    sx_neg         <= !(lx0 < lx1);
                    sy_neg         <= !(ly0 < ly1);
                    cx             <= lx0;
                    cy             <= ly0;
                    point_valid    <= 1'b1;
                    point_occupied <= (lx0 == lx1) && (ly0 == ly1);
                    state          <= STEP;
                end
                STEP: begin
                    if (point_ready) begin
                        if (at_end) begin
                            busy           <= 1'b0;
                            point_valid    <= 1'b0;
                            point_occupied <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            cx             <= next_x;
                            cy             <= next_y;
                            err            <= next_err;
                            point_occupied <= (next_x == lx1) && (next_y == ly1);
                        end
                    end
                end
                default: begin
                    busy        <= 1'b0;
                    point_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
